// File: rtl/note_display_sequencer_pkg.sv
// Shared scan codes, state encodings and helpers for the note display sequencer.
package note_seq_pkg;

   localparam logic [7:0] NOTE_C   = 8'h23;
   localparam logic [7:0] NOTE_D   = 8'h2D;
   localparam logic [7:0] NOTE_E   = 8'h3A;
   localparam logic [7:0] NOTE_F   = 8'h2B;
   localparam logic [7:0] NOTE_G   = 8'h1B;
   localparam logic [7:0] NOTE_A   = 8'h4B;
   localparam logic [7:0] NOTE_B   = 8'h21;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_BRK,
      DEC_EXT,
      DEC_EXT_BRK
   } dec_state_t;

   typedef enum logic {
      D_IDLE,
      D_SHOW
   } disp_state_t;

   function automatic logic is_note(input logic [7:0] code);
      case (code)
         NOTE_C, NOTE_D, NOTE_E, NOTE_F, NOTE_G, NOTE_A, NOTE_B: return 1'b1;
         default:                                                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/note_display_sequencer_if.sv
// Keyboard byte stream in, vga scan code and status out.
interface note_display_sequencer_if #(
   parameter int DEPTH = 4
);
   import note_seq_pkg::*;

   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic                    vsync;
   logic [7:0]              scan;
   logic [$clog2(DEPTH):0]  queue_count;
   logic                    overflow;
   logic                    showing;

   modport master (
      output rx_data, rx_valid, vsync,
      input  scan, queue_count, overflow, showing
   );

   modport slave (
      input  rx_data, rx_valid, vsync,
      output scan, queue_count, overflow, showing
   );

endinterface

// File: rtl/note_display_sequencer_fifo.sv
// Synchronous FIFO for queued note codes; flush empties it in one cycle.
module note_fifo
   import note_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk_100MHz,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];

   // A full queue still takes a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);

   // Pointer and occupancy tracking.
   always_ff @(posedge clk_100MHz) begin
      if (reset || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk_100MHz) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/note_display_sequencer.sv
// Decodes PS/2 scan codes into a note queue and steps the displayed note on frame boundaries.
//
// Decoder states:
//   DEC_IDLE    | waiting for a make code or prefix
//   DEC_BRK     | F0 seen, next byte is the released key
//   DEC_EXT     | E0 seen, extended key follows
//   DEC_EXT_BRK | E0 F0 seen, next byte is an ignored extended release
// Display states:
//   D_IDLE      | nothing held, waiting for a queued note at a frame tick
//   D_SHOW      | a note is on screen, counting frames
module note_display_sequencer
   import note_seq_pkg::*;
#(
   parameter int         DEPTH       = 4,
   parameter int         HOLD_FRAMES = 30,
   parameter logic [7:0] BLANK_CODE  = 8'h00
) (
   input  logic                  clk_100MHz,
   input  logic                  reset,
   note_display_sequencer_if.slave bus
);

   localparam int            CW       = $clog2(HOLD_FRAMES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_FRAMES - 1);

   logic                    vsync_d;
   logic                    frame_tick;

   dec_state_t              dec_q, dec_d;
   logic [7:0]              held_q, held_d;
   logic                    esc_pending_q;
   logic                    esc_set;
   logic                    dec_push;

   disp_state_t             disp_q, disp_d;
   logic [7:0]              scan_q, scan_d;
   logic                    showing_q, showing_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    overflow_q;
   logic                    esc_clr;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_flush;
   logic [7:0]              fifo_head;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign frame_tick = bus.vsync & ~vsync_d;

   // Edge detector for the vga vsync.
   always_ff @(posedge clk_100MHz) begin
      if (reset) vsync_d <= 1'b0;
      else       vsync_d <= bus.vsync;
   end

   // Decoder next state; only acts on received bytes.
   always_comb begin
      dec_d    = dec_q;
      held_d   = held_q;
      esc_set  = 1'b0;
      dec_push = 1'b0;
      if (bus.rx_valid) begin
         case (dec_q)
            DEC_IDLE: begin
               if (bus.rx_data == SC_BREAK) begin
                  dec_d = DEC_BRK;
               end else if (bus.rx_data == SC_EXT) begin
                  dec_d = DEC_EXT;
               end else if (is_note(bus.rx_data)) begin
                  // A repeat of the still-held key is typematic, not a new press.
                  dec_push = (bus.rx_data != held_q);
                  held_d   = bus.rx_data;
               end else if (bus.rx_data == SC_ESC) begin
                  esc_set = 1'b1;
               end
            end
            DEC_BRK: begin
               if (bus.rx_data == held_q) held_d = 8'h00;
               dec_d = DEC_IDLE;
            end
            DEC_EXT: begin
               dec_d = (bus.rx_data == SC_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
            end
            default: dec_d = DEC_IDLE;
         endcase
      end
   end

   // Decoder registers and the pending escape request.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         dec_q         <= DEC_IDLE;
         held_q        <= 8'h00;
         esc_pending_q <= 1'b0;
      end else begin
         dec_q  <= dec_d;
         held_q <= held_d;
         if (esc_set)      esc_pending_q <= 1'b1;
         else if (esc_clr) esc_pending_q <= 1'b0;
      end
   end

   // Display next state; evaluated only on frame ticks so the glyph never tears.
   always_comb begin
      disp_d     = disp_q;
      scan_d     = scan_q;
      showing_d  = showing_q;
      cnt_d      = cnt_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      esc_clr    = 1'b0;
      if (frame_tick) begin
         if (esc_pending_q) begin
            fifo_flush = 1'b1;
            esc_clr    = 1'b1;
            scan_d     = SC_ESC;
            showing_d  = 1'b0;
            disp_d     = D_IDLE;
         end else begin
            case (disp_q)
               D_IDLE: begin
                  if (!fifo_empty) begin
                     fifo_pop  = 1'b1;
                     scan_d    = fifo_head;
                     cnt_d     = '0;
                     showing_d = 1'b1;
                     disp_d    = D_SHOW;
                  end
               end
               default: begin
                  if (cnt_q < CNT_LAST) begin
                     cnt_d = cnt_q + 1'b1;
                  end else if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     scan_d   = fifo_head;
                     cnt_d    = '0;
                  end else begin
                     scan_d    = BLANK_CODE;
                     showing_d = 1'b0;
                     disp_d    = D_IDLE;
                  end
               end
            endcase
         end
      end
   end

   // Display registers.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         disp_q    <= D_IDLE;
         scan_q    <= BLANK_CODE;
         showing_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         disp_q    <= disp_d;
         scan_q    <= scan_d;
         showing_q <= showing_d;
         cnt_q     <= cnt_d;
      end
   end

   // A flush in the same cycle swallows the new note.
   assign fifo_push = dec_push & ~fifo_flush;

   // Sticky drop flag, cleared only by escape.
   always_ff @(posedge clk_100MHz) begin
      if (reset)                                      overflow_q <= 1'b0;
      else if (esc_clr)                               overflow_q <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)   overflow_q <= 1'b1;
   end

   note_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .push       (fifo_push),
      .push_data  (bus.rx_data),
      .pop        (fifo_pop),
      .flush      (fifo_flush),
      .pop_data   (fifo_head),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign bus.scan        = scan_q;
   assign bus.showing     = showing_q;
   assign bus.overflow    = overflow_q;
   assign bus.queue_count = fifo_count;

endmodule
